// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext -- single-clock FIFO with exact status flags.
//
// Producer and consumer share one clock. The FIFO provides:
//   - a fill level
//   - programmable almost-full and almost-empty flags
//   - sticky overflow and underflow error flags
//   - a selectable first-word-fall-through (FWFT) read mode
// All 2**ASIZE entries are usable.
//
// Parameters
//   DSIZE           data word width
//   ASIZE           address width, depth = 2**ASIZE
//   FWFT            0: rdata registered on an accepted read
//                   1: head word shown combinationally while not empty
//   AWFULL_THRESH   awfull when level >= AWFULL_THRESH
//   AREMPTY_THRESH  arempty when level <= AREMPTY_THRESH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   winc       write request
//   wdata      write data
//   wfull      level == depth
//   awfull     almost full
//   rinc       read request
//   rdata      read data
//   rempty     level == 0
//   arempty    almost empty
//   level      words stored, 0..depth
//   err_clr    clears overflow/underflow (a same-cycle set wins)
//   overflow   sticky, set by winc while full
//   underflow  sticky, set by rinc while empty
module sync_fifo_ext #(
  parameter int DSIZE          = 32,
  parameter int ASIZE          = 4,
  parameter int FWFT           = 0,
  parameter int AWFULL_THRESH  = 12,
  parameter int AREMPTY_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty,
  output logic [ASIZE:0]   level,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AWFULL_LVL  = (ASIZE+1)'(AWFULL_THRESH);
  localparam logic [ASIZE:0] AREMPTY_LVL = (ASIZE+1)'(AREMPTY_THRESH);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE:0]   wptr_next;
  logic [ASIZE:0]   rptr_next;
  logic [ASIZE:0]   level_next;
  logic             w_acc;
  logic             r_acc;
  logic             full_next;
  logic             empty_next;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] raddr;

  // Accept decisions use the registered flags from before the edge.
  // This is why a write to a full FIFO is refused even when a read
  // happens in the same cycle.
  // One extra pointer bit separates full from empty when the low bits
  // are equal. The level is the wrapped pointer difference, so all
  // flags follow the pointers exactly.
  always_comb begin
    w_acc      = winc & ~wfull;
    r_acc      = rinc & ~rempty;
    wptr_next  = wptr + {{ASIZE{1'b0}}, w_acc};
    rptr_next  = rptr + {{ASIZE{1'b0}}, r_acc};
    level_next = wptr_next - rptr_next;
    full_next  = (wptr_next[ASIZE] != rptr_next[ASIZE]) &&
                 (wptr_next[ASIZE-1:0] == rptr_next[ASIZE-1:0]);
    empty_next = (wptr_next == rptr_next);
    waddr      = wptr[ASIZE-1:0];
    raddr      = rptr[ASIZE-1:0];
  end

  // Pointers and every status flag update on the edge that accepts the
  // operation, so the flags describe the FIFO contents after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      wfull   <= 1'b0;
      rempty  <= 1'b1;
      awfull  <= 1'b0;
      arempty <= 1'b1;
    end else begin
      wptr    <= wptr_next;
      rptr    <= rptr_next;
      level   <= level_next;
      wfull   <= full_next;
      rempty  <= empty_next;
      awfull  <= (level_next >= AWFULL_LVL);
      arempty <= (level_next <= AREMPTY_LVL);
    end
  end

  // Error flags are sticky. A new error in the same cycle as err_clr
  // keeps the flag set, so the event is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull) begin
        overflow <= 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
      end
      if (rinc && rempty) begin
        underflow <= 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
      end
    end
  end

  // Storage has no reset. Stale contents are never visible, because the
  // pointers restart at zero and rdata is forced or reset separately.
  always_ff @(posedge clk) begin
    if (w_acc && rst_n) begin
      mem[waddr] <= wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is shown directly from the memory array. A word
      // written into an empty FIFO appears as soon as rempty falls.
      always_comb begin
        rdata = '0;
        if (!rempty) begin
          rdata = mem[raddr];
        end
      end
    end else begin : g_std
      logic [DSIZE-1:0] rdata_reg;

      // Registered read: the popped word appears after the read edge.
      // rdata holds its value when no read is accepted.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_reg <= '0;
        end else if (r_acc) begin
          rdata_reg <= mem[raddr];
        end
      end

      always_comb begin
        rdata = rdata_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// tb_sync_fifo_ext -- drives one registered-read FIFO and one FWFT FIFO
// with the same stimulus.
// The reference is a word queue plus plain level arithmetic. Popped
// words for the registered-read copy go to a scoreboard queue, and a
// monitor checks both DUTs after every clock edge.
module tb_sync_fifo_ext;

  logic        clk;
  logic        rst_n;
  logic        winc;
  logic [31:0] wdata;
  logic        rinc;
  logic        err_clr;

  logic        wfull0, awfull0, rempty0, arempty0, overflow0, underflow0;
  logic [31:0] rdata0;
  logic [4:0]  level0;
  logic        wfull1, awfull1, rempty1, arempty1, overflow1, underflow1;
  logic [31:0] rdata1;
  logic [4:0]  level1;

  int unsigned vectors;
  int unsigned miscompares;

  logic [31:0] model_q [$];
  logic [31:0] exp_rd0 [$];
  logic [31:0] rd_hold0;
  logic        model_ovf;
  logic        model_unf;

  sync_fifo_ext #(.DSIZE(32), .ASIZE(4), .FWFT(0),
                  .AWFULL_THRESH(12), .AREMPTY_THRESH(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata),
    .wfull(wfull0), .awfull(awfull0), .rinc(rinc), .rdata(rdata0),
    .rempty(rempty0), .arempty(arempty0), .level(level0),
    .err_clr(err_clr), .overflow(overflow0), .underflow(underflow0)
  );

  sync_fifo_ext #(.DSIZE(32), .ASIZE(4), .FWFT(1),
                  .AWFULL_THRESH(12), .AREMPTY_THRESH(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .winc(winc), .wdata(wdata),
    .wfull(wfull1), .awfull(awfull1), .rinc(rinc), .rdata(rdata1),
    .rempty(rempty1), .arempty(arempty1), .level(level1),
    .err_clr(err_clr), .overflow(overflow1), .underflow(underflow1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and advances the
  // reference to its state after the next rising edge.
  task automatic applyStimulus(input logic w, input logic [31:0] d,
                               input logic r, input logic c);
    int n;
    logic [31:0] head;
    @(negedge clk);
    winc = w; wdata = d; rinc = r; err_clr = c;
    n = model_q.size();
    if (w && n == 16) model_ovf = 1'b1;
    else if (c) model_ovf = 1'b0;
    if (r && n == 0) model_unf = 1'b1;
    else if (c) model_unf = 1'b0;
    if (r && n > 0) begin
      head = model_q.pop_front();
      exp_rd0.push_back(head);
    end
    if (w && n < 16) model_q.push_back(d);
    @(posedge clk);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " rempty0"}, 32'(rempty0), 32'd1);
    checkOutput({tag, " arempty0"}, 32'(arempty0), 32'd1);
    checkOutput({tag, " wfull0"}, 32'(wfull0), 32'd0);
    checkOutput({tag, " awfull0"}, 32'(awfull0), 32'd0);
    checkOutput({tag, " level0"}, 32'(level0), 32'd0);
    checkOutput({tag, " rdata0"}, rdata0, 32'd0);
    checkOutput({tag, " ovf0"}, 32'(overflow0), 32'd0);
    checkOutput({tag, " unf0"}, 32'(underflow0), 32'd0);
    checkOutput({tag, " rempty1"}, 32'(rempty1), 32'd1);
    checkOutput({tag, " arempty1"}, 32'(arempty1), 32'd1);
    checkOutput({tag, " wfull1"}, 32'(wfull1), 32'd0);
    checkOutput({tag, " level1"}, 32'(level1), 32'd0);
    checkOutput({tag, " rdata1"}, rdata1, 32'd0);
    checkOutput({tag, " unf1"}, 32'(underflow1), 32'd0);
  endtask

  // Asserts reset between clock edges and checks that the outputs
  // clear before any edge arrives.
  task automatic pulseReset();
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkResetState("async");
    model_q.delete();
    exp_rd0.delete();
    rd_hold0  = '0;
    model_ovf = 1'b0;
    model_unf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: after each edge, compare both DUTs with the reference.
  // A queued pop entry is the rdata the registered-read copy must show.
  always @(posedge clk) begin
    int n;
    #1;
    if (rst_n) begin
      n = model_q.size();
      checkOutput("level0", 32'(level0), 32'(n));
      checkOutput("level1", 32'(level1), 32'(n));
      checkOutput("wfull0", 32'(wfull0), 32'(n == 16));
      checkOutput("wfull1", 32'(wfull1), 32'(n == 16));
      checkOutput("rempty0", 32'(rempty0), 32'(n == 0));
      checkOutput("rempty1", 32'(rempty1), 32'(n == 0));
      checkOutput("awfull0", 32'(awfull0), 32'(n >= 12));
      checkOutput("awfull1", 32'(awfull1), 32'(n >= 12));
      checkOutput("arempty0", 32'(arempty0), 32'(n <= 2));
      checkOutput("arempty1", 32'(arempty1), 32'(n <= 2));
      checkOutput("overflow0", 32'(overflow0), 32'(model_ovf));
      checkOutput("overflow1", 32'(overflow1), 32'(model_ovf));
      checkOutput("underflow0", 32'(underflow0), 32'(model_unf));
      checkOutput("underflow1", 32'(underflow1), 32'(model_unf));
      if (exp_rd0.size() > 0) rd_hold0 = exp_rd0.pop_front();
      checkOutput("rdata0", rdata0, rd_hold0);
      checkOutput("rdata1", rdata1, (n == 0) ? 32'd0 : model_q[0]);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    rd_hold0    = '0;
    model_ovf   = 1'b0;
    model_unf   = 1'b0;
    rst_n   = 1'b0;
    winc    = 1'b0;
    rinc    = 1'b0;
    err_clr = 1'b0;
    wdata   = '0;
    #12 checkResetState("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 checkResetState("post_reset");

    // Fill completely, try one write too many, then drain in order.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Stream across the pointer wrap while holding the level at one.
    applyStimulus(1'b1, 32'h1000, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) applyStimulus(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Full FIFO with a write and a read together: the write is refused.
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Underflow, then a clear, then a clear that collides with a new underflow.
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    // Reset in the middle of a run, then a single word after release.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    pulseReset();
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // Random traffic in phases that alternately fill and drain.
    for (int i = 0; i < 400; i++) begin
      int wp;
      int rp;
      wp = ((i / 50) % 2 == 1) ? 80 : 30;
      rp = 110 - wp;
      applyStimulus($urandom_range(99) < wp, $urandom, $urandom_range(99) < rp,
                    $urandom_range(15) == 0);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
